// File: rtl/pipe_stage_pkg.sv
// Shared pipeline-stage types: occupancy state of a two-entry skid stage.
package pipe_stage_pkg;

  // Encoding doubles as the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  function automatic logic [1:0] occOf(input stage_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            clear,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  // Clear wins over increment; increment stops at the maximum value.
  always_ff @(posedge CLK) begin
    if (clear) count <= '0;
    else if (inc && (count != {CNTW{1'b1}})) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage with stall, flush, sticky halt and a
// saturating count of cycles where downstream was ready but idle.
module pipe_skid_stage
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic             halted,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  bubble_count
);

  stage_state_t     state, stateNext;
  logic [WIDTH-1:0] headData, skidData;
  logic             headHalt, skidHalt;
  logic             doAccept, doRelease;
  logic             loadHead, loadSkid, shiftSkid;
  logic             bubbleInc;

  assign in_ready  = (state != FULL) && !stall && !halted;
  assign out_valid = (state != EMPTY) && !stall;
  assign out_data  = headData;
  assign out_halt  = headHalt;
  assign occupancy = occOf(state);

  assign doAccept  = in_valid && in_ready;
  assign doRelease = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= EMPTY;
    else     state <= stateNext;
  end

  // Next state and entry-movement strobes; flush overrides any transfer.
  always_comb begin
    stateNext = state;
    loadHead  = 1'b0;
    loadSkid  = 1'b0;
    shiftSkid = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: if (doAccept) begin
          stateNext = ONE;
          loadHead  = 1'b1;
        end
        ONE: begin
          if (doAccept && doRelease) begin
            loadHead = 1'b1;
          end else if (doAccept) begin
            stateNext = FULL;
            loadSkid  = 1'b1;
          end else if (doRelease) begin
            stateNext = EMPTY;
          end
        end
        FULL: if (doRelease) begin
          stateNext = ONE;
          shiftSkid = 1'b1;
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // Head and skid entry storage; skid advances into head on release from FULL.
  always_ff @(posedge CLK) begin
    if (RST) begin
      headData <= '0;
      headHalt <= 1'b0;
      skidData <= '0;
      skidHalt <= 1'b0;
    end else begin
      if (loadHead) begin
        headData <= in_data;
        headHalt <= in_halt;
      end else if (shiftSkid) begin
        headData <= skidData;
        headHalt <= skidHalt;
      end
      if (loadSkid) begin
        skidData <= in_data;
        skidHalt <= in_halt;
      end
    end
  end

  // Sticky halt: set once a halt-marked entry leaves, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) halted <= 1'b0;
    else if (doRelease && headHalt) halted <= 1'b1;
  end

  assign bubbleInc = out_ready && !out_valid && !halted && !flush && !stall;

  sat_counter #(.CNTW(CNTW)) uBubble (
    .CLK   (CLK),
    .clear (RST),
    .inc   (bubbleInc),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: streaming, backpressure, stall/flush,
// sticky halt, saturating bubble counter and reset mid-operation.
module tb_pipe_skid_stage;

  localparam int WIDTH = 8;
  localparam int CNTW  = 2;

  logic             CLK = 1'b0;
  logic             RST, in_valid, in_halt, out_ready, stall, flush;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid, out_halt, halted;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNTW-1:0]  bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_skid_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_halt      (in_halt),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_halt     (out_halt),
    .out_ready    (out_ready),
    .stall        (stall),
    .flush        (flush),
    .halted       (halted),
    .occupancy    (occupancy),
    .bubble_count (bubble_count)
  );

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idleInputs();
    RST = 1'b0; in_valid = 1'b0; in_halt = 1'b0; in_data = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (bubble_count !== 2'd0) begin errors++; $display("FAIL reset_bubble got %0d exp 0", bubble_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] vals [3] = '{8'h01, 8'h02, 8'h03};
    doReset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      checks++; if (out_data !== vals[i]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, vals[i]); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occupancy); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_backpressure();
    doReset();
    in_valid = 1'b1; in_data = 8'h0A;
    tick();
    in_data = 8'h0B;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d exp 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (out_data !== 8'h0A) begin errors++; $display("FAIL bp_first got %h exp 0a", out_data); end
    tick();
    checks++; if (out_data !== 8'h0B) begin errors++; $display("FAIL bp_second got %h exp 0b", out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_after1 got %0d exp 1", occupancy); end
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got occ %0d valid %b exp 0 0", occupancy, out_valid); end
  endtask

  task automatic test_stall_flush();
    doReset();
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    stall = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_out_valid got %b exp 0", out_valid); end
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stall_hold_occ got %0d exp 2", occupancy); end
    checks++; if (bubble_count !== 2'd0) begin errors++; $display("FAIL stall_bubble got %0d exp 0", bubble_count); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h44 || occupancy !== 2'd1) begin errors++; $display("FAIL flush_refill got %h occ %0d exp 44 1", out_data, occupancy); end
  endtask

  task automatic test_halt();
    doReset();
    out_ready = 1'b1; in_valid = 1'b1; in_halt = 1'b1; in_data = 8'h05;
    tick();
    in_valid = 1'b0; in_halt = 1'b0;
    #1;
    checks++; if (out_halt !== 1'b1) begin errors++; $display("FAIL halt_marker got %b exp 1", out_halt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b exp 0", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halted); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got %b exp 0", in_ready); end
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 8'h06;
    #1;
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_after_flush got halted %b ready %b exp 1 0", halted, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL halt_blocks_accept got %0d exp 0", occupancy); end
    doReset();
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL halt_cleared got halted %b ready %b exp 0 1", halted, in_ready); end
  endtask

  task automatic test_bubble();
    logic [CNTW-1:0] expv [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bubble_count !== expv[i]) begin errors++; $display("FAIL bubble[%0d] got %0d exp %0d", i, bubble_count, expv[i]); end
    end
  endtask

  task automatic test_reset_full();
    doReset();
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstfull_pre_occ got %0d exp 2", occupancy); end
    out_ready = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstfull_state got occ %0d valid %b exp 0 0", occupancy, out_valid); end
    checks++; if (bubble_count !== 2'd0) begin errors++; $display("FAIL rstfull_bubble got %0d exp 0", bubble_count); end
    checks++; if (out_data !== 8'h00 || out_halt !== 1'b0) begin errors++; $display("FAIL rstfull_head got %h %b exp 00 0", out_data, out_halt); end
  endtask

  initial begin
    idleInputs();
    RST = 1'b1;
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall_flush();
    test_halt();
    test_bubble();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
